// File: rtl/layer_scheduler.sv
// layer_scheduler
//   Sequences the convolution engines one layer at a time: a one-cycle
//   engine clear, then for each layer raise its enable, wait for the rising
//   edge of that engine's valid, drop the enable and hold a drain gap so the
//   last SRAM writes land. The SRAM ping-pong select flips at every layer
//   boundary.
//
//   Optional feature macro: LAYER_TIMEOUT_EN
//     Adds a per-layer watchdog (TIMEOUT_CYCLES) and the ERR state. Without
//     it the TIMEOUT_CYCLES parameter does not exist, error is tied to 0 and
//     RUN waits indefinitely.
//
// Ports
//   clk, rst_n    clock, async active-low reset
//   start         one-cycle request to run the layer chain (IDLE/ERR only)
//   abort         synchronous return to IDLE, highest priority
//   layer_valid   per-engine done level
//   layer_enable  per-engine enable, one-hot or zero
//   eng_rst_n     engine clear, active-low, low for the single CLR cycle
//   src_sel       0: read A / write B, 1: read B / write A
//   layer_idx     current or most recent layer
//   busy          high from CLR through DONE
//   done          one-cycle completion pulse
//   error         sticky watchdog flag
//   All outputs are registered.
module layer_scheduler #(
    parameter int NUM_LAYERS = 3,
    parameter int GAP_CYCLES = 4
`ifdef LAYER_TIMEOUT_EN
    , parameter logic [15:0] TIMEOUT_CYCLES = 16'd4000
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_valid,
    output logic [NUM_LAYERS-1:0] layer_enable,
    output logic                  eng_rst_n,
    output logic                  src_sel,
    output logic [1:0]            layer_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_LAYERS - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_RUN, S_DRAIN, S_DONE
`ifdef LAYER_TIMEOUT_EN
        , S_ERR
`endif
    } state_t;

    state_t                  state, state_nxt;
    logic                    v_d, v_d_nxt;
    logic [7:0]              gap, gap_nxt;
    logic [1:0]              idx_nxt;
    logic                    src_nxt;
    logic [NUM_LAYERS-1:0]   en_nxt;
    logic                    erst_nxt, busy_nxt, done_nxt;
    logic                    v_edge;

    assign v_edge = layer_valid[layer_idx] & ~v_d;

`ifdef LAYER_TIMEOUT_EN
    logic [15:0] wd_cnt, wd_nxt;
    logic        err_nxt;
    logic        wd_hit;
    assign wd_hit = (wd_cnt == TIMEOUT_CYCLES - 16'd1);
`else
    assign error = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            v_d          <= 1'b0;
            gap          <= '0;
            layer_idx    <= '0;
            src_sel      <= 1'b0;
            layer_enable <= '0;
            eng_rst_n    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef LAYER_TIMEOUT_EN
            wd_cnt       <= '0;
            error        <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            v_d          <= v_d_nxt;
            gap          <= gap_nxt;
            layer_idx    <= idx_nxt;
            src_sel      <= src_nxt;
            layer_enable <= en_nxt;
            eng_rst_n    <= erst_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
`ifdef LAYER_TIMEOUT_EN
            wd_cnt       <= wd_nxt;
            error        <= err_nxt;
`endif
        end
    end

    // Next-state logic; abort wins over start and over a valid edge
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_CLR;
                S_CLR:   state_nxt = S_RUN;
                S_RUN: begin
                    if (v_edge) state_nxt = S_DRAIN;
`ifdef LAYER_TIMEOUT_EN
                    else if (wd_hit) state_nxt = S_ERR;
`endif
                end
                S_DRAIN: if (gap == 8'd0) state_nxt = (layer_idx == LAST_IDX) ? S_DONE : S_RUN;
                S_DONE:  state_nxt = S_IDLE;
`ifdef LAYER_TIMEOUT_EN
                S_ERR:   if (start) state_nxt = S_CLR;
`endif
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs, decoded from the transition
    always_comb begin
        idx_nxt = layer_idx;
        src_nxt = src_sel;
        gap_nxt = gap;
        if (state_nxt == S_CLR) begin
            idx_nxt = '0;
            src_nxt = 1'b0;
        end else if (state == S_DRAIN && state_nxt == S_RUN) begin
            idx_nxt = layer_idx + 2'd1;
            src_nxt = ~src_sel;
        end

        if (state == S_RUN && state_nxt == S_DRAIN)
            gap_nxt = GAP_LOAD;
        else if (state == S_DRAIN && gap != 8'd0)
            gap_nxt = gap - 8'd1;

        // v_d always holds the previous sample of the bit for the layer that
        // will be running, so a bit already high on RUN entry forms no edge.
        en_nxt  = '0;
        v_d_nxt = 1'b0;
        if (state_nxt == S_RUN) begin
            en_nxt[idx_nxt] = 1'b1;
            v_d_nxt         = layer_valid[idx_nxt];
        end

        erst_nxt = (state_nxt != S_CLR);
        busy_nxt = (state_nxt == S_CLR) || (state_nxt == S_RUN) ||
                   (state_nxt == S_DRAIN) || (state_nxt == S_DONE);
        done_nxt = (state_nxt == S_DONE);
`ifdef LAYER_TIMEOUT_EN
        err_nxt  = (state_nxt == S_ERR);
        wd_nxt   = (state == S_RUN && state_nxt == S_RUN) ? wd_cnt + 16'd1 : 16'd0;
`endif
    end

endmodule

// File: tb/tb_layer_scheduler.sv
module tb_layer_scheduler;
    localparam int NL  = 3;
    localparam int GAP = 4;

    typedef int lat_t [NL];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NL-1:0] layer_valid = '0;
    logic [NL-1:0] layer_enable;
    logic          eng_rst_n, src_sel, busy, done, error;
    logic [1:0]    layer_idx;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    layer_scheduler #(
        .NUM_LAYERS(NL),
        .GAP_CYCLES(GAP)
`ifdef LAYER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16'd50)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .layer_valid(layer_valid), .layer_enable(layer_enable),
        .eng_rst_n(eng_rst_n), .src_sel(src_sel), .layer_idx(layer_idx),
        .busy(busy), .done(done), .error(error)
    );

    // Reference timeline: cycle 0 carries start. CLR is cycle 1, layer 0
    // enables at 2; engine k's valid rises in cycle v[k] = e[k] + lat[k];
    // the next enable follows 1+GAP cycles later; done sits in the cycle
    // 1+GAP after the last valid edge. Checks at each negedge; inputs for
    // cycle c are driven right after its check.
    task automatic run_chain(input lat_t lat, input int hold0, input int junk2,
                             input bit noise, input string tag);
        int e[NL];
        int v[NL];
        int d, xidx;
        logic [NL-1:0] xen;
        logic [NL+6:0] got, exp;
        e[0] = 2;
        for (int k = 0; k < NL; k++) begin
            v[k] = e[k] + lat[k];
            if (k < NL - 1) e[k+1] = v[k] + 1 + GAP;
        end
        d = v[NL-1] + 1 + GAP;
        for (int c = 0; c <= d + 2; c++) begin
            @(negedge clk);
            xen = '0;
            xidx = 0;
            for (int k = 0; k < NL; k++) begin
                if (c >= e[k] && c <= v[k]) xen[k] = 1'b1;
                if (k > 0 && c >= e[k]) xidx = k;
            end
            got = {layer_enable, eng_rst_n, busy, done, error, layer_idx, src_sel};
            exp = {xen, (c != 1), (c >= 1 && c <= d), (c == d), 1'b0,
                   2'(xidx), 1'(xidx % 2)};
            if (c == 0) begin
                got[2:0] = 3'b000;   // idx/src hold the previous chain's values
                exp[2:0] = 3'b000;
            end
            vecs++;
            if (got !== exp) begin
                errs++;
                $display("FAIL %s c=%0d got en=%b erst=%b busy=%b done=%b err=%b idx=%0d src=%b, want en=%b erst=%b busy=%b done=%b err=%b idx=%0d src=%b",
                         tag, c, got[NL+6:7], got[6], got[5], got[4], got[3], got[2:1], got[0],
                         exp[NL+6:7], exp[6], exp[5], exp[4], exp[3], exp[2:1], exp[0]);
            end
            // start outside IDLE must be ignored
            start = (c == 0) || (noise && c >= 1 && c <= d && ($urandom_range(0, 5) == 0));
            for (int k = 0; k < NL; k++) layer_valid[k] = (c >= v[k]);
            if (hold0 > 0 && c < e[0] + hold0) layer_valid[0] = 1'b1;
            if (junk2 > 0 && c >= e[0] && c < e[0] + junk2) layer_valid[NL-1] = 1'b1;
        end
        start = 1'b0;
        layer_valid = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vecs++;
        if ({layer_enable, eng_rst_n, src_sel, layer_idx, busy, done, error} !== {3'b000, 1'b1, 1'b0, 2'd0, 3'b000}) begin
            errs++;
            $display("FAIL reset got en=%b erst=%b src=%b idx=%0d busy=%b done=%b err=%b, want 000 1 0 0 0 0 0",
                     layer_enable, eng_rst_n, src_sel, layer_idx, busy, done, error);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vecs++;
        if ({layer_enable, eng_rst_n, busy, done} !== {3'b000, 1'b1, 2'b00}) begin
            errs++;
            $display("FAIL idle_after_reset got en=%b erst=%b busy=%b done=%b, want 000 1 0 0",
                     layer_enable, eng_rst_n, busy, done);
        end
    endtask

    task automatic test_directed();
        lat_t l;
        l = '{100, 100, 100};
        run_chain(l, 0, 0, 1'b0, "directed");
    endtask

    task automatic test_random_chains();
        lat_t l;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < NL; k++) l[k] = $urandom_range(1, 25);
            run_chain(l, 0, 0, 1'b1, "random");
        end
    endtask

    task automatic test_hold_valid();
        lat_t l;
        int h;
        for (int i = 0; i < 2; i++) begin
            h = $urandom_range(3, 10);
            l[0] = h + $urandom_range(2, 8);
            for (int k = 1; k < NL; k++) l[k] = $urandom_range(1, 15);
            run_chain(l, h, 0, 1'b0, "hold_valid");
        end
    endtask

    task automatic test_foreign_valid();
        lat_t l;
        int j;
        j = $urandom_range(3, 8);
        l[0] = j + $urandom_range(3, 10);
        for (int k = 1; k < NL; k++) l[k] = $urandom_range(1, 15);
        run_chain(l, 0, j, 1'b0, "foreign_valid");
    endtask

    task automatic test_abort_on_edge();
        int l0, l1, v0, e1, v1;
        lat_t l;
        l0 = $urandom_range(2, 12);
        l1 = $urandom_range(2, 12);
        v0 = 2 + l0;
        e1 = v0 + 1 + GAP;
        v1 = e1 + l1;
        for (int c = 0; c <= v1 + 6; c++) begin
            @(negedge clk);
            if (c == v1) begin
                vecs++;
                if (layer_enable !== 3'b010 || layer_idx !== 2'd1) begin
                    errs++;
                    $display("FAIL abort_pre got en=%b idx=%0d, want en=010 idx=1", layer_enable, layer_idx);
                end
            end
            if (c == v1 + 1) begin
                vecs++;
                if ({layer_enable, eng_rst_n, busy, done, layer_idx, src_sel} !== {3'b000, 1'b1, 2'b00, 2'd1, 1'b1}) begin
                    errs++;
                    $display("FAIL abort_now got en=%b erst=%b busy=%b done=%b idx=%0d src=%b, want 000 1 0 0 1 1",
                             layer_enable, eng_rst_n, busy, done, layer_idx, src_sel);
                end
            end
            if (c > v1 + 1) begin
                vecs++;
                if (done !== 1'b0 || busy !== 1'b0 || layer_enable !== 3'b000) begin
                    errs++;
                    $display("FAIL abort_after c=%0d got done=%b busy=%b en=%b, want 0 0 000", c, done, busy, layer_enable);
                end
            end
            start = (c == 0);
            layer_valid[0] = (c >= v0);
            layer_valid[1] = (c >= v1);
            abort = (c == v1);
        end
        abort = 1'b0;
        layer_valid = '0;
        for (int k = 0; k < NL; k++) l[k] = $urandom_range(1, 10);
        run_chain(l, 0, 0, 1'b0, "restart_after_abort");
    endtask

    task automatic test_async_reset();
        int l0, l1, v0, v1;
        l0 = $urandom_range(1, 8);
        l1 = $urandom_range(1, 8);
        v0 = 2 + l0;
        v1 = v0 + 1 + GAP + l1;
        for (int c = 0; c <= v1 + 2; c++) begin
            @(negedge clk);
            start = (c == 0);
            layer_valid[0] = (c >= v0);
            layer_valid[1] = (c >= v1);
        end
        start = 1'b0;
        vecs++;
        if (busy !== 1'b1 || layer_idx !== 2'd1 || src_sel !== 1'b1 || layer_enable !== 3'b000) begin
            errs++;
            $display("FAIL pre_async_reset got busy=%b idx=%0d src=%b en=%b, want 1 1 1 000",
                     busy, layer_idx, src_sel, layer_enable);
        end
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if ({layer_enable, eng_rst_n, src_sel, layer_idx, busy, done, error} !== {3'b000, 1'b1, 1'b0, 2'd0, 3'b000}) begin
            errs++;
            $display("FAIL async_reset got en=%b erst=%b src=%b idx=%0d busy=%b done=%b err=%b, want 000 1 0 0 0 0 0",
                     layer_enable, eng_rst_n, src_sel, layer_idx, busy, done, error);
        end
        layer_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vecs++;
        if (busy !== 1'b0 || layer_enable !== 3'b000) begin
            errs++;
            $display("FAIL post_async_reset got busy=%b en=%b, want 0 000", busy, layer_enable);
        end
    endtask

`ifdef LAYER_TIMEOUT_EN
    task automatic test_timeout();
        for (int c = 0; c <= 60; c++) begin
            @(negedge clk);
            if (c == 51) begin
                vecs++;
                if (layer_enable !== 3'b001 || error !== 1'b0) begin
                    errs++;
                    $display("FAIL timeout_pre got en=%b err=%b, want 001 0", layer_enable, error);
                end
            end
            if (c == 52) begin
                vecs++;
                if (layer_enable !== 3'b000 || error !== 1'b1 || busy !== 1'b0) begin
                    errs++;
                    $display("FAIL timeout_hit got en=%b err=%b busy=%b, want 000 1 0", layer_enable, error, busy);
                end
            end
            if (c == 56) begin
                vecs++;
                if (error !== 1'b0 || busy !== 1'b1 || eng_rst_n !== 1'b0 || layer_idx !== 2'd0) begin
                    errs++;
                    $display("FAIL timeout_restart got err=%b busy=%b erst=%b idx=%0d, want 0 1 0 0",
                             error, busy, eng_rst_n, layer_idx);
                end
            end
            if (c == 58) begin
                vecs++;
                if (busy !== 1'b0 || layer_enable !== 3'b000) begin
                    errs++;
                    $display("FAIL timeout_abort got busy=%b en=%b, want 0 000", busy, layer_enable);
                end
            end
            start = (c == 0) || (c == 55);
            abort = (c == 57);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random_chains();
        test_hold_valid();
        test_foreign_valid();
        test_abort_on_edge();
        test_async_reset();
`ifdef LAYER_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/layer_scheduler.md
# layer_scheduler

Top-level sequencer for the convolution engines. It runs them one layer at a time: it pulses a clearing reset, raises each engine's `enable`, waits for that engine's `valid` rising edge, and inserts a drain gap so the last SRAM writes commit. It also flips the ping-pong select between SRAM groups A and B at every layer boundary. It sits between the host start/done handshake and the engines' `enable`/`valid` pins, and its `src_sel` drives the SRAM port muxes.

## Interface
Parameters:
- `NUM_LAYERS`, 3: engines sequenced; legal range 2..4.
- `GAP_CYCLES`, 4: drain cycles between layers; legal range 1..255.
- `TIMEOUT_CYCLES`, 16'd4000: cycle limit per layer for the watchdog (used only with `LAYER_TIMEOUT_EN`).

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: one-cycle request to run the full layer chain.
- `abort`  in  1: synchronous abort; returns the block to IDLE.
- `layer_valid`  in  `NUM_LAYERS`: per-engine done level. Bit i is the `valid` of engine i.
- `layer_enable`  out  `NUM_LAYERS`: per-engine enable; one-hot or zero, registered.
- `eng_rst_n`  out  1: synchronous clear to all engines, active-low, registered.
- `src_sel`  out  1: 0 means read group A and write group B; 1 means the reverse.
- `layer_idx`  out  2: index of the current or most recent layer.
- `busy`  out  1: high from the CLR state through the DONE state.
- `done`  out  1: one-cycle pulse when the chain completes.
- `error`  out  1: sticky watchdog flag; tied to 0 without `LAYER_TIMEOUT_EN`.

## Operation
- FSM states: IDLE, CLR, RUN, DRAIN, DONE, and ERR (ERR exists only with the macro).
- IDLE:
  - `start`=1 → CLR. On that edge, `layer_idx`←0 and `src_sel`←0.
  - `start` is ignored in every state except IDLE and ERR.
- CLR: lasts exactly 1 cycle with `eng_rst_n`=0, then → RUN with `layer_enable[layer_idx]`=1.
- RUN:
  - Keep the valid bit from the previous cycle, `v_d`.
  - A rising edge (`layer_valid[layer_idx]`=1 and `v_d`=0) → DRAIN. `layer_enable`←0 and gap counter←`GAP_CYCLES`-1.
  - `v_d` is cleared in CLR. A valid bit that is already high gives no edge.
  - `layer_valid` bits other than `layer_idx` are ignored.
- DRAIN: the gap counter decrements each cycle. At 0:
  - if `layer_idx`==`NUM_LAYERS`-1 → DONE;
  - otherwise `layer_idx`+1, `src_sel` toggles, and → RUN with the new enable bit set.
- DONE: `done`=1 for 1 cycle, then → IDLE. `layer_idx` and `src_sel` keep their final values.
- `abort`=1 in any state:
  - → IDLE on the next edge; `layer_enable`←0 and `eng_rst_n`←1.
  - `abort` takes priority over `start` and over a simultaneous valid edge. A `done` pulse is not generated.
- Reset values: state=IDLE, `layer_enable`=0, `eng_rst_n`=1, `src_sel`=0, `layer_idx`=0, `busy`=0, `done`=0, `error`=0, `v_d`=0, all counters 0.
- A `rst_n` assertion mid-layer clears everything immediately, including enables, without waiting for a clock.

## Timing
- All outputs are registered. No combinational path exists from any input to any output.
- `start` sampled at edge t: `eng_rst_n`=0 and `busy`=1 during cycle t+1; `layer_enable[0]`=1 from t+2.
- Valid edge sampled at edge v: enable is low from v+1. The next enable is high from v+1+`GAP_CYCLES`.
- Last-layer edge at v: `done`=1 during cycle v+1+`GAP_CYCLES`; `busy`=0 from the following cycle.
- Per-layer overhead is 1+`GAP_CYCLES` cycles. Chain overhead is 1 (CLR) + `NUM_LAYERS`×(1+`GAP_CYCLES`).

## Configuration
- `LAYER_TIMEOUT_EN` defined:
  - A 16-bit cycle counter clears on RUN entry and increments each cycle in RUN.
  - Reaching `TIMEOUT_CYCLES` without a valid edge → ERR: `layer_enable`←0, `error`←1, `busy`←0.
  - ERR exits to CLR on `start` (clearing `error` and `layer_idx`) or to IDLE on `abort` (clearing `error`).
- `LAYER_TIMEOUT_EN` undefined: no counter and no ERR state; `error` is constant 0, and RUN waits indefinitely.

## Test plan
- Reset, then `start` at cycle 5 with layer `valid` edges 100 cycles after each enable (`NUM_LAYERS`=3, `GAP_CYCLES`=4) → `eng_rst_n` low in cycle 6 only; enables rise at 7, 112, 217; `src_sel` 0, 1, 0; `done` pulse at 322.
- Hold `layer_valid[0]`=1 across `start` → no edge forms after CLR; the block stays in RUN until valid drops and rises again.
- Drive `valid` for a non-current layer (bit 2 high while layer 0 is running) → ignored; `layer_idx` stays 0.
- `abort` on the same cycle as a valid edge during layer 1 → IDLE next cycle; enables 0; no `done`; a later `start` restarts at layer 0 with `src_sel`=0.
- Assert `rst_n` low asynchronously mid-DRAIN → all outputs take their reset values before the next clock edge.
- With `LAYER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=50, never assert `valid` → `error`=1 and enables 0 after 50 RUN cycles; `start` clears `error` and restarts.
